// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame receiver.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StCsum,
    StSkip
  } rx_state_e;

  localparam logic [1:0] ERR_ABORT    = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_NO_SPACE = 2'd2;
  localparam logic [1:0] ERR_BAD_CSUM = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_rx_fifo.sv
// Commit/rewind FIFO: writes stay invisible to the reader until committed,
// and a rewind discards everything written since the last commit.
module spi_rx_fifo #(
  parameter int unsigned DEPTH = 128,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [8:0]    i_wr_data,
  input  logic          i_commit,
  input  logic          i_rewind,
  output logic [PW-1:0] o_free,
  output logic          o_valid,
  output logic [7:0]    o_data,
  output logic          o_last,
  input  logic          i_ready
);

  logic [8:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_commit;
  logic [PW-1:0] r_rd;
  logic          r_valid;
  logic [7:0]    r_data;
  logic          r_last;

  logic          w_empty;
  logic          w_load;

  assign w_empty = (r_rd == r_commit);
  assign w_load  = (!r_valid || i_ready) && !w_empty;
  // Space is measured against committed data only; the frame in flight is not counted.
  assign o_free  = PW'(DEPTH) - (r_commit - r_rd);

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[r_wr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr     <= '0;
      r_commit <= '0;
      r_rd     <= '0;
      r_valid  <= 1'b0;
      r_data   <= 8'd0;
      r_last   <= 1'b0;
    end else begin
      if (i_rewind) begin
        r_wr <= r_commit;
      end else if (i_wr_en) begin
        r_wr <= r_wr + PW'(1);
      end
      if (i_commit) begin
        r_commit <= r_wr;
      end
      if (w_load) begin
        {r_last, r_data} <= r_mem[r_rd[AW-1:0]];
        r_valid          <= 1'b1;
        r_rd             <= r_rd + PW'(1);
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_frame_rx.sv
// Frame parser behind spi_slave: SOF | LEN | payload | CSUM, releasing payload
// downstream only once the XOR checksum verifies.
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned DEPTH   = 128,
  parameter logic [7:0]  SOF     = SOF_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_en_i,
  input  logic [7:0] data_i,
  input  logic       spi_ss_i,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  rx_state_e     r_state, w_state_d;
  logic [7:0]    r_cnt, w_cnt_d;
  logic [7:0]    r_csum, w_csum_d;
  logic [8:0]    r_skip, w_skip_d;
  logic          r_ok, w_ok_d;
  logic          r_err, w_err_d;
  logic [1:0]    r_code, w_code_d;

  logic          w_wr_en;
  logic [8:0]    w_wr_data;
  logic [PW-1:0] w_free;
  logic          w_len_bad;
  logic          w_no_space;

  assign w_len_bad  = (data_i == 8'd0) || (32'(data_i) > MAX_LEN);
  assign w_no_space = 32'(w_free) < 32'(data_i);
  assign w_wr_data  = {(r_cnt == 8'd1), data_i};

  assign frame_ok  = r_ok;
  assign frame_err = r_err;
  assign err_code  = r_code;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_csum_d  = r_csum;
    w_skip_d  = r_skip;
    w_ok_d    = 1'b0;
    w_err_d   = 1'b0;
    w_code_d  = r_code;
    w_wr_en   = 1'b0;
    if (spi_ss_i) begin
      // Deselect overrides any byte strobe in the same cycle.
      if (r_state inside {StLen, StPayload, StCsum}) begin
        w_err_d  = 1'b1;
        w_code_d = ERR_ABORT;
      end
      w_state_d = StIdle;
    end else if (data_en_i) begin
      unique case (r_state)
        StIdle: begin
          if (data_i == SOF) w_state_d = StLen;
        end
        StLen: begin
          if (w_len_bad) begin
            w_err_d   = 1'b1;
            w_code_d  = ERR_BAD_LEN;
            w_state_d = StIdle;
          end else if (w_no_space) begin
            w_err_d   = 1'b1;
            w_code_d  = ERR_NO_SPACE;
            w_skip_d  = {1'b0, data_i} + 9'd1;
            w_state_d = StSkip;
          end else begin
            w_cnt_d   = data_i;
            w_csum_d  = data_i;
            w_state_d = StPayload;
          end
        end
        StPayload: begin
          w_wr_en  = 1'b1;
          w_csum_d = r_csum ^ data_i;
          w_cnt_d  = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_state_d = StCsum;
        end
        StCsum: begin
          if (data_i == r_csum) begin
            w_ok_d = 1'b1;
          end else begin
            w_err_d  = 1'b1;
            w_code_d = ERR_BAD_CSUM;
          end
          w_state_d = StIdle;
        end
        StSkip: begin
          w_skip_d = r_skip - 9'd1;
          if (r_skip == 9'd1) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
      r_csum  <= 8'd0;
      r_skip  <= 9'd0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= ERR_ABORT;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_csum  <= w_csum_d;
      r_skip  <= w_skip_d;
      r_ok    <= w_ok_d;
      r_err   <= w_err_d;
      r_code  <= w_code_d;
    end
  end

  // Commit/rewind follow the registered pulses; rewinding on BAD_LEN or
  // NO_SPACE is harmless because nothing uncommitted exists then.
  spi_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_commit  (r_ok),
    .i_rewind  (r_err),
    .o_free    (w_free),
    .o_valid   (m_valid),
    .o_data    (m_data),
    .o_last    (m_last),
    .i_ready   (m_ready)
  );

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx with hand-computed frames and expected output.
module tb_spi_frame_rx;

  logic       clk;
  logic       rst;
  logic       data_en_i;
  logic [7:0] data_i;
  logic       spi_ss_i;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int errors = 0;
  int checks = 0;
  int n_ok   = 0;
  int n_err  = 0;
  logic [8:0] q_out[$];

  spi_frame_rx #(
    .MAX_LEN (64),
    .DEPTH   (128),
    .SOF     (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_en_i (data_en_i),
    .data_i    (data_i),
    .spi_ss_i  (spi_ss_i),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_valid && m_ready) q_out.push_back({m_last, m_data});
    if (frame_ok) n_ok++;
    if (frame_err) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    data_en_i = 1'b1;
    data_i    = b;
    @(posedge clk); #1;
    data_en_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [8:0] exp);
    logic [8:0] v;
    v = 'x;
    if (q_out.size() > 0) v = q_out.pop_front();
    chk(tag, {23'd0, v}, {23'd0, exp});
  endtask

  int ok0;
  int err0;
  logic [7:0] csum;
  logic [7:0] b;

  initial begin
    rst = 1'b1; data_en_i = 1'b0; data_i = 8'd0; spi_ss_i = 1'b0; m_ready = 1'b0;
    idle(3);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_frame_ok", {31'd0, frame_ok}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    rst = 1'b0;
    m_ready = 1'b1;
    idle(2);

    // Good frame and output latency
    ok0 = n_ok; err0 = n_err;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    chk("good_frame_ok_pulse", {31'd0, frame_ok}, 32'd1);
    chk("good_valid_e0", {31'd0, m_valid}, 32'd0);
    idle(1);
    chk("good_valid_e1", {31'd0, m_valid}, 32'd0);
    idle(1);
    chk("good_valid_e2", {31'd0, m_valid}, 32'd1);
    chk("good_first_data", {24'd0, m_data}, 32'h11);
    idle(5);
    chk("good_q_size", q_out.size(), 32'd3);
    expect_out("good_b0", 9'h011);
    expect_out("good_b1", 9'h022);
    expect_out("good_b2", 9'h133);
    chk("good_ok_count", n_ok - ok0, 32'd1);
    chk("good_err_count", n_err - err0, 32'd0);

    // Bad checksum, then rewind proven by an intact retransmission
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
    chk("csum_err_pulse", {31'd0, frame_err}, 32'd1);
    chk("csum_err_code", {30'd0, err_code}, 32'd3);
    idle(5);
    chk("csum_no_output", q_out.size(), 32'd0);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    idle(6);
    chk("rewind_q_size", q_out.size(), 32'd3);
    expect_out("rewind_b0", 9'h011);
    expect_out("rewind_b1", 9'h022);
    expect_out("rewind_b2", 9'h133);

    // Bad length
    send(8'hA5); send(8'h00);
    chk("len0_err_pulse", {31'd0, frame_err}, 32'd1);
    chk("len0_err_code", {30'd0, err_code}, 32'd1);
    idle(2);
    send(8'hA5); send(8'h41);
    chk("len65_err_pulse", {31'd0, frame_err}, 32'd1);
    chk("len65_err_code", {30'd0, err_code}, 32'd1);
    idle(2);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    chk("len1_ok_pulse", {31'd0, frame_ok}, 32'd1);
    idle(5);
    chk("len1_q_size", q_out.size(), 32'd1);
    expect_out("len1_b0", 9'h17E);

    // Chip-select abort, including same-cycle strobe
    err0 = n_err; ok0 = n_ok;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22);
    spi_ss_i = 1'b1;
    idle(1);
    spi_ss_i = 1'b0;
    chk("abort_err_pulse", {31'd0, frame_err}, 32'd1);
    chk("abort_err_code", {30'd0, err_code}, 32'd0);
    idle(2);
    send(8'hA5); send(8'h03); send(8'h11);
    data_en_i = 1'b1; data_i = 8'h22; spi_ss_i = 1'b1;
    @(posedge clk); #1;
    data_en_i = 1'b0; spi_ss_i = 1'b0;
    chk("abort_same_cycle_pulse", {31'd0, frame_err}, 32'd1);
    chk("abort_same_cycle_code", {30'd0, err_code}, 32'd0);
    idle(2);
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
    idle(5);
    chk("abort_err_count", n_err - err0, 32'd2);
    chk("abort_ok_count", n_ok - ok0, 32'd1);
    chk("abort_q_size", q_out.size(), 32'd2);
    expect_out("abort_b0", 9'h0AA);
    expect_out("abort_b1", 9'h1BB);

    // Backpressure: two full-size frames, one held in the output register.
    // Free space is then 128 - 127 = 1, so a LEN=2 frame must be refused.
    m_ready = 1'b0;
    idle(2);
    for (int f = 0; f < 2; f++) begin
      csum = 8'd64;
      send(8'hA5); send(8'd64);
      for (int i = 0; i < 64; i++) begin
        b = 8'(f * 64 + i);
        csum ^= b;
        send(b);
      end
      send(csum);
      chk("bp_frame_ok", {31'd0, frame_ok}, 32'd1);
      idle(2);
    end
    chk("bp_hold_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_hold_data", {23'd0, m_last, m_data}, 32'h000);
    err0 = n_err;
    send(8'hA5); send(8'h02);
    chk("nospace_err_pulse", {31'd0, frame_err}, 32'd1);
    chk("nospace_err_code", {30'd0, err_code}, 32'd2);
    send(8'h55); send(8'h54); send(8'h56);
    idle(3);
    chk("nospace_single_err", n_err - err0, 32'd1);
    chk("bp_stable_data", {23'd0, m_last, m_data}, 32'h000);
    chk("bp_no_handshake", q_out.size(), 32'd0);
    m_ready = 1'b1;
    idle(140);
    chk("bp_q_size", q_out.size(), 32'd128);
    for (int i = 0; i < 128; i++) begin
      expect_out("bp_byte", {(i == 63 || i == 127), 8'(i)});
    end
    send(8'hA5); send(8'h02); send(8'hC1); send(8'hC2); send(8'h01);
    idle(5);
    chk("wrap_q_size", q_out.size(), 32'd2);
    expect_out("wrap_b0", 9'h0C1);
    expect_out("wrap_b1", 9'h1C2);

    // Reset mid-payload
    ok0 = n_ok; err0 = n_err;
    send(8'hA5); send(8'h03); send(8'h11);
    rst = 1'b1;
    idle(1);
    chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("midrst_err_code", {30'd0, err_code}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    idle(1);
    send(8'hA5); send(8'h01); send(8'h99); send(8'h98);
    idle(5);
    chk("midrst_ok_count", n_ok - ok0, 32'd1);
    chk("midrst_err_count", n_err - err0, 32'd0);
    chk("midrst_q_size", q_out.size(), 32'd1);
    expect_out("midrst_b0", 9'h199);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
